// File: rtl/bldc_hall_pwm_drive.sv
`default_nettype none
// ============================================================================
// Module      : bldc_hall_pwm_drive
// Description : Six-step BLDC drive core. Synchronizes the hall sensors,
//               selects the commutation step, PWMs the high-side gate,
//               enforces per-leg dead time, flags hall faults and counts
//               hall transitions.
// Revision    : 1.0 - initial release
// ============================================================================
module bldc_hall_pwm_drive #(
    parameter int PHASE_DRIVER_MAX_COUNTER = 'h1FF,
    parameter int MAX_DUTY_CYCLE           = 'h1FF,
    parameter int DUTY_CYCLE_STEP_RES      = 1,
    parameter int DEAD_TIME                = 20,
    parameter int COUNTER_WIDTH            = 7,
    // Derived duty width; leave at its default.
    parameter int DW                       = $clog2(MAX_DUTY_CYCLE + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     direction,
    input  logic [DW-1:0]            duty_cycle,
    input  logic [2:0]               hall,
    input  logic                     count_clr,
    output logic [2:0]               phaseH,
    output logic [2:0]               phaseL,
    output logic                     connected,
    output logic                     fault,
    output logic [COUNTER_WIDTH-1:0] hall_count
);

    localparam int c_cnt_w = $clog2(PHASE_DRIVER_MAX_COUNTER + 1);
    localparam int c_dt_w  = (DEAD_TIME < 1) ? 1 : $clog2(DEAD_TIME + 1);
    localparam int c_cmp_w = (c_cnt_w > DW) ? c_cnt_w : DW;

    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(PHASE_DRIVER_MAX_COUNTER);
    localparam logic [DW-1:0]      c_duty_max = DW'(MAX_DUTY_CYCLE);
    localparam logic [DW-1:0]      c_res      = DW'(DUTY_CYCLE_STEP_RES);
    localparam logic [c_dt_w-1:0]  c_dead     = c_dt_w'(DEAD_TIME);

    // Next state in the forward hall order; 000 for states outside 1..6.
    function automatic logic [2:0] f_fwd_next(input logic [2:0] s);
        case (s)
            3'b001:  f_fwd_next = 3'b011;
            3'b011:  f_fwd_next = 3'b010;
            3'b010:  f_fwd_next = 3'b110;
            3'b110:  f_fwd_next = 3'b100;
            3'b100:  f_fwd_next = 3'b101;
            3'b101:  f_fwd_next = 3'b001;
            default: f_fwd_next = 3'b000;
        endcase
    endfunction

    logic [2:0]               r_hall_meta;
    logic [2:0]               r_hs;
    logic [2:0]               r_hs_prev;
    logic                     r_fault;
    logic                     r_connected;
    logic [COUNTER_WIDTH-1:0] r_count;
    logic [c_cnt_w-1:0]       r_pwm_cnt;
    logic [DW-1:0]            r_duty;

    logic          w_hs_valid;
    logic          w_prev_valid;
    logic          w_hs_change;
    logic          w_adjacent;
    logic          w_fault_set;
    logic          w_fault_any;
    logic          w_drive_ok;
    logic [DW-1:0] w_duty_sat;
    logic [DW-1:0] w_duty_q;
    logic [DW-1:0] w_duty_cur;
    logic          w_pwm;
    logic          w_low_on;
    logic [2:0]    w_sel_h;
    logic [2:0]    w_sel_l;
    logic [2:0]    w_req_h;
    logic [2:0]    w_req_l;
    logic [2:0]    w_phase_h;
    logic [2:0]    w_phase_l;

    // Two-stage synchronizer; resets to "disconnected" so no fault is seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hall_meta <= 3'b111;
            r_hs        <= 3'b111;
        end else begin
            r_hall_meta <= hall;
            r_hs        <= r_hall_meta;
        end
    end

    assign w_hs_valid   = (r_hs != 3'b000) && (r_hs != 3'b111);
    assign w_prev_valid = (r_hs_prev != 3'b000) && (r_hs_prev != 3'b111);
    assign w_hs_change  = w_hs_valid && w_prev_valid && (r_hs != r_hs_prev);
    assign w_adjacent   = (f_fwd_next(r_hs_prev) == r_hs) || (f_fwd_next(r_hs) == r_hs_prev);
    assign w_fault_set  = (r_hs == 3'b000) || (w_hs_change && !w_adjacent);
    // A fault being detected this cycle already blocks the gates on the next edge.
    assign w_fault_any  = r_fault || w_fault_set;
    assign w_drive_ok   = en && !w_fault_any && w_hs_valid;

    // Hall status: previous state, sticky fault, connection and transition count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hs_prev   <= 3'b111;
            r_fault     <= 1'b0;
            r_connected <= 1'b0;
            r_count     <= '0;
        end else begin
            r_hs_prev   <= r_hs;
            r_fault     <= w_fault_any;
            r_connected <= (r_hs != 3'b111);
            if (count_clr) begin
                r_count <= '0;
            end else if (w_hs_change) begin
                r_count <= r_count + COUNTER_WIDTH'(1);
            end
        end
    end

    // Duty is sampled only while the counter sits at 0 and held for the period.
    assign w_duty_sat = (duty_cycle > c_duty_max) ? c_duty_max : duty_cycle;
    assign w_duty_q   = (w_duty_sat / c_res) * c_res;
    assign w_duty_cur = (r_pwm_cnt == '0) ? w_duty_q : r_duty;
    assign w_pwm      = c_cmp_w'(r_pwm_cnt) < c_cmp_w'(w_duty_cur);
    assign w_low_on   = (w_duty_cur != '0);

    // PWM period counter and per-period duty latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pwm_cnt <= '0;
            r_duty    <= '0;
        end else begin
            r_pwm_cnt <= (r_pwm_cnt == c_cnt_max) ? '0 : r_pwm_cnt + c_cnt_w'(1);
            r_duty    <= w_duty_cur;
        end
    end

    // Forward commutation table: one-hot high-side phase and low-side phase.
    always_comb begin
        w_sel_h = 3'b000;
        w_sel_l = 3'b000;
        case (r_hs)
            3'b001: begin w_sel_h = 3'b001; w_sel_l = 3'b010; end
            3'b011: begin w_sel_h = 3'b001; w_sel_l = 3'b100; end
            3'b010: begin w_sel_h = 3'b010; w_sel_l = 3'b100; end
            3'b110: begin w_sel_h = 3'b010; w_sel_l = 3'b001; end
            3'b100: begin w_sel_h = 3'b100; w_sel_l = 3'b001; end
            3'b101: begin w_sel_h = 3'b100; w_sel_l = 3'b010; end
            default: begin w_sel_h = 3'b000; w_sel_l = 3'b000; end
        endcase
    end

    // Reverse rotation simply swaps which phase is switched high and low.
    assign w_req_h = w_drive_ok ? ((direction ? w_sel_l : w_sel_h) & {3{w_pwm}})    : 3'b000;
    assign w_req_l = w_drive_ok ? ((direction ? w_sel_h : w_sel_l) & {3{w_low_on}}) : 3'b000;

    for (genvar i = 0; i < 3; i++) begin : g_leg
        logic              r_h;
        logic              r_l;
        logic [c_dt_w-1:0] r_dt;
        logic              w_dt_done;

        assign w_dt_done = (r_dt == '0);

        // Gate pair of one leg: drops immediately, rises only after the leg
        // has been fully off long enough for the dead-time counter to expire.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_h  <= 1'b0;
                r_l  <= 1'b0;
                r_dt <= c_dead;
            end else begin
                r_h <= w_req_h[i] && (r_h || (w_dt_done && !r_l));
                r_l <= w_req_l[i] && (r_l || (w_dt_done && !r_h));
                if (r_h || r_l) begin
                    r_dt <= c_dead;
                end else if (!w_dt_done) begin
                    r_dt <= r_dt - c_dt_w'(1);
                end
            end
        end

        assign w_phase_h[i] = r_h;
        assign w_phase_l[i] = r_l;
    end

    assign phaseH     = w_phase_h;
    assign phaseL     = w_phase_l;
    assign connected  = r_connected;
    assign fault      = r_fault;
    assign hall_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_bldc_hall_pwm_drive.sv
`default_nettype none
// ============================================================================
// Module      : tb_bldc_hall_pwm_drive
// Description : Directed self-checking bench for bldc_hall_pwm_drive.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bldc_hall_pwm_drive;

    localparam int DW = 9;
    localparam int CW = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          direction;
    logic [DW-1:0] duty_cycle;
    logic [2:0]    hall;
    logic          count_clr;
    logic [2:0]    phaseH;
    logic [2:0]    phaseL;
    logic          connected;
    logic          fault;
    logic [CW-1:0] hall_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bldc_hall_pwm_drive dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .direction  (direction),
        .duty_cycle (duty_cycle),
        .hall       (hall),
        .count_clr  (count_clr),
        .phaseH     (phaseH),
        .phaseL     (phaseL),
        .connected  (connected),
        .fault      (fault),
        .hall_count (hall_count)
    );

    // Advance n clocks; inputs and samples both happen 1 ns after the edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0; direction = 1'b0; duty_cycle = '0;
        hall = 3'b111; count_clr = 1'b0;
        tick(3);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1; en = 1'b1; direction = 1'b0; duty_cycle = 9'd256;
        hall = 3'b001; count_clr = 1'b0;
        tick(3);
        checks++; if (phaseH !== 3'b000) begin errors++; $display("FAIL reset_phaseH: got %b expected 000", phaseH); end
        checks++; if (phaseL !== 3'b000) begin errors++; $display("FAIL reset_phaseL: got %b expected 000", phaseL); end
        checks++; if (connected !== 1'b0) begin errors++; $display("FAIL reset_connected: got %b expected 0", connected); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fault); end
        checks++; if (hall_count !== 7'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", hall_count); end
        reset = 1'b0;
        n = 0;
        while (phaseL === 3'b000 && n < 60) begin tick(1); n++; end
        checks++; if (n <= 20) begin errors++; $display("FAIL reset_deadtime: low gate rose after %0d clocks, required > 20", n); end
        checks++; if (phaseL !== 3'b010) begin errors++; $display("FAIL reset_first_low: got %b expected 010", phaseL); end
    endtask

    task automatic test_forward();
        logic [2:0] seq   [7];
        logic [2:0] exp_h [7];
        logic [2:0] exp_l [7];
        int hi, bad_h, bad_l;
        seq   = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101, 3'b001};
        exp_h = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
        exp_l = '{3'b010, 3'b100, 3'b100, 3'b001, 3'b001, 3'b010, 3'b010};
        do_reset();
        en = 1'b1; duty_cycle = 9'd256;
        for (int k = 0; k < 7; k++) begin
            hall = seq[k];
            tick(600);
            hi = 0; bad_h = 0; bad_l = 0;
            for (int s = 0; s < 512; s++) begin
                tick(1);
                if (phaseH === exp_h[k]) hi++;
                else if (phaseH !== 3'b000) bad_h++;
                if (phaseL !== exp_l[k]) bad_l++;
            end
            checks++; if (hi != 256) begin errors++; $display("FAIL fwd_duty step %0d: high %0d clocks expected 256", k, hi); end
            checks++; if (bad_h != 0) begin errors++; $display("FAIL fwd_phaseH step %0d: %0d wrong samples expected 0 (want %b)", k, bad_h, exp_h[k]); end
            checks++; if (bad_l != 0) begin errors++; $display("FAIL fwd_phaseL step %0d: %0d wrong samples expected 0 (want %b)", k, bad_l, exp_l[k]); end
            checks++; if (hall_count !== CW'(k)) begin errors++; $display("FAIL fwd_count step %0d: got %0d expected %0d", k, hall_count, k); end
            checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fwd_fault step %0d: got %b expected 0", k, fault); end
            checks++; if (connected !== 1'b1) begin errors++; $display("FAIL fwd_connected step %0d: got %b expected 1", k, connected); end
            tick(888);
        end
    endtask

    task automatic test_count_wrap();
        do_reset();
        hall = 3'b001;
        tick(4);
        for (int i = 1; i <= 127; i++) begin
            hall = (i % 2 == 1) ? 3'b011 : 3'b001;
            tick(4);
        end
        checks++; if (hall_count !== 7'd127) begin errors++; $display("FAIL wrap_127: got %0d expected 127", hall_count); end
        hall = 3'b001;
        tick(4);
        checks++; if (hall_count !== 7'd0) begin errors++; $display("FAIL wrap_0: got %0d expected 0", hall_count); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL wrap_fault: got %b expected 0", fault); end
    endtask

    task automatic test_reverse();
        int n, off, hi, bad_h, bad_l;
        do_reset();
        en = 1'b1; duty_cycle = 9'd256; hall = 3'b001;
        tick(600);
        n = 0;
        while (phaseH[0] !== 1'b1 && n < 600) begin tick(1); n++; end
        checks++; if (phaseH[0] !== 1'b1) begin errors++; $display("FAIL rev_setup: A high got %b expected 1", phaseH[0]); end
        direction = 1'b1;
        tick(1);
        checks++; if (phaseH[0] !== 1'b0) begin errors++; $display("FAIL rev_A_high_off: got %b expected 0", phaseH[0]); end
        off = 0;
        while (phaseL[0] !== 1'b1 && off < 60) begin
            if (phaseH[0] === 1'b0) off++;
            tick(1);
        end
        checks++; if (phaseL[0] !== 1'b1) begin errors++; $display("FAIL rev_A_low_rise: got %b expected 1", phaseL[0]); end
        checks++; if (off < 20) begin errors++; $display("FAIL rev_deadtime: leg A off %0d clocks expected >= 20", off); end
        tick(600);
        hi = 0; bad_h = 0; bad_l = 0;
        for (int s = 0; s < 512; s++) begin
            tick(1);
            if (phaseH === 3'b010) hi++;
            else if (phaseH !== 3'b000) bad_h++;
            if (phaseL !== 3'b001) bad_l++;
        end
        checks++; if (hi != 256) begin errors++; $display("FAIL rev_duty: high %0d clocks expected 256", hi); end
        checks++; if (bad_h != 0) begin errors++; $display("FAIL rev_phaseH: %0d wrong samples expected 0", bad_h); end
        checks++; if (bad_l != 0) begin errors++; $display("FAIL rev_phaseL: %0d wrong samples expected 0", bad_l); end
    endtask

    task automatic test_fault();
        do_reset();
        en = 1'b1; duty_cycle = 9'd256; hall = 3'b001;
        tick(600);
        checks++; if (phaseL !== 3'b010) begin errors++; $display("FAIL fault_pre_low: got %b expected 010", phaseL); end
        hall = 3'b010;
        tick(2);
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_latency: got %b expected 0", fault); end
        tick(1);
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_set: got %b expected 1", fault); end
        checks++; if (phaseH !== 3'b000) begin errors++; $display("FAIL fault_phaseH: got %b expected 000", phaseH); end
        checks++; if (phaseL !== 3'b000) begin errors++; $display("FAIL fault_phaseL: got %b expected 000", phaseL); end
        hall = 3'b001;
        tick(200);
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_sticky: got %b expected 1", fault); end
        checks++; if ((phaseH | phaseL) !== 3'b000) begin errors++; $display("FAIL fault_gates_held: got %b expected 000", phaseH | phaseL); end
    endtask

    task automatic test_disconnect();
        do_reset();
        en = 1'b1; duty_cycle = 9'd256; hall = 3'b001;
        tick(600);
        checks++; if (connected !== 1'b1) begin errors++; $display("FAIL disc_pre: got %b expected 1", connected); end
        hall = 3'b111;
        tick(4);
        checks++; if (connected !== 1'b0) begin errors++; $display("FAIL disc_connected: got %b expected 0", connected); end
        checks++; if ((phaseH | phaseL) !== 3'b000) begin errors++; $display("FAIL disc_gates: got %b expected 000", phaseH | phaseL); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL disc_fault: got %b expected 0", fault); end
        hall = 3'b000;
        tick(4);
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL zero_fault: got %b expected 1", fault); end
    endtask

    task automatic test_duty();
        int n, run, on;
        logic prev;
        do_reset();
        en = 1'b1; duty_cycle = 9'd0; hall = 3'b001;
        tick(600);
        on = 0;
        for (int s = 0; s < 512; s++) begin tick(1); if ((phaseH | phaseL) !== 3'b000) on++; end
        checks++; if (on != 0) begin errors++; $display("FAIL duty0_gates: %0d active samples expected 0", on); end
        duty_cycle = 9'd100;
        tick(1100);
        prev = phaseH[0]; n = 0;
        tick(1);
        while (!(prev === 1'b0 && phaseH[0] === 1'b1) && n < 1100) begin prev = phaseH[0]; tick(1); n++; end
        checks++; if (phaseH[0] !== 1'b1) begin errors++; $display("FAIL duty_find_rise: got %b expected 1", phaseH[0]); end
        run = 1;
        repeat (49) begin tick(1); if (phaseH[0] === 1'b1) run++; end
        duty_cycle = 9'd300;
        n = 0;
        while (phaseH[0] === 1'b1 && n < 600) begin tick(1); n++; if (phaseH[0] === 1'b1) run++; end
        checks++; if (run != 100) begin errors++; $display("FAIL duty_old_period: high %0d clocks expected 100", run); end
        n = 0;
        while (phaseH[0] !== 1'b1 && n < 600) begin tick(1); n++; end
        run = 0; n = 0;
        while (phaseH[0] === 1'b1 && n < 600) begin run++; tick(1); n++; end
        checks++; if (run != 300) begin errors++; $display("FAIL duty_new_period: high %0d clocks expected 300", run); end
    endtask

    task automatic test_en_drop();
        int n;
        do_reset();
        en = 1'b1; duty_cycle = 9'd256; hall = 3'b001;
        tick(600);
        n = 0;
        while (phaseH[0] !== 1'b1 && n < 600) begin tick(1); n++; end
        en = 1'b0;
        tick(1);
        checks++; if (phaseH !== 3'b000) begin errors++; $display("FAIL en_drop_phaseH: got %b expected 000", phaseH); end
        checks++; if (phaseL !== 3'b000) begin errors++; $display("FAIL en_drop_phaseL: got %b expected 000", phaseL); end
    endtask

    task automatic test_count_clr();
        do_reset();
        hall = 3'b001; tick(4);
        hall = 3'b011; tick(4);
        hall = 3'b001; tick(4);
        checks++; if (hall_count !== 7'd2) begin errors++; $display("FAIL clr_pre: got %0d expected 2", hall_count); end
        hall = 3'b011;
        tick(2);
        count_clr = 1'b1;
        tick(1);
        count_clr = 1'b0;
        checks++; if (hall_count !== 7'd0) begin errors++; $display("FAIL clr_priority: got %0d expected 0", hall_count); end
        hall = 3'b001;
        tick(4);
        checks++; if (hall_count !== 7'd1) begin errors++; $display("FAIL clr_resume: got %0d expected 1", hall_count); end
    endtask

    task automatic test_async_reset();
        int n;
        do_reset();
        en = 1'b1; duty_cycle = 9'd256; hall = 3'b001;
        tick(4);
        hall = 3'b011;
        tick(600);
        n = 0;
        while (phaseH[0] !== 1'b1 && n < 600) begin tick(1); n++; end
        checks++; if (hall_count !== 7'd1 || phaseH !== 3'b001 || phaseL !== 3'b100) begin
            errors++; $display("FAIL areset_pre: got count %0d H %b L %b expected 1 001 100", hall_count, phaseH, phaseL);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (phaseH !== 3'b000) begin errors++; $display("FAIL areset_phaseH: got %b expected 000", phaseH); end
        checks++; if (phaseL !== 3'b000) begin errors++; $display("FAIL areset_phaseL: got %b expected 000", phaseL); end
        checks++; if (hall_count !== 7'd0) begin errors++; $display("FAIL areset_count: got %0d expected 0", hall_count); end
        checks++; if (connected !== 1'b0) begin errors++; $display("FAIL areset_connected: got %b expected 0", connected); end
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; direction = 1'b0; duty_cycle = '0;
        hall = 3'b111; count_clr = 1'b0;
        test_reset();
        test_forward();
        test_count_wrap();
        test_reverse();
        test_fault();
        test_disconnect();
        test_duty();
        test_en_drop();
        test_count_clr();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
